mul_rep_add: RTL



---
 rtl/mul_rep_add_if.sv | 13 +
 rtl/mul_rep_add.sv | 65 ++++++
 2 files changed

// File: rtl/mul_rep_add_if.sv
// mul_rep_add_if: start/operand request and busy/done/product response of mul_rep_add.
interface mul_rep_add_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    modport master(output start, a_in, b_in, input busy, done, product);
    modport slave(input start, a_in, b_in, output busy, done, product);
endinterface

// File: rtl/mul_rep_add.sv
// mul_rep_add: unsigned multiplier by repeated addition under a start/done handshake.
// Define MUL_RA_SWAP_EN to add the larger operand min(a,b) times instead of a_in b_in times.
module mul_rep_add #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    mul_rep_add_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state;
    logic [WIDTH-1:0]   mcand, count, ld_mcand, ld_count;
    logic [2*WIDTH-1:0] acc, product;
    logic               busy, done;
`ifdef MUL_RA_SWAP_EN
    // fewer adds of the larger operand give the same product sooner
    always_comb begin
        ld_mcand = (bus.a_in < bus.b_in) ? bus.b_in : bus.a_in;
        ld_count = (bus.a_in < bus.b_in) ? bus.a_in : bus.b_in;
    end
`else
    always_comb begin
        ld_mcand = bus.a_in;
        ld_count = bus.b_in;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            count   <= '0;
            mcand   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= CALC;
                    busy  <= 1'b1;
                    mcand <= ld_mcand;
                    count <= ld_count;
                    acc   <= '0;
                end
                CALC: if (count != '0) begin
                    acc   <= acc + {{WIDTH{1'b0}}, mcand};
                    count <= count - WIDTH'(1);
                end else begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    product <= acc;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule
